vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator: joint horizontal/vertical counters with sync,

---
 rtl/vga_timing_gen.sv | 117 +++++++++++
 tb/tb_vga_timing_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: joint pixel/line counters with registered sync, active-video,
// line/frame strobes and a completed-frame counter, all advancing on the pixel strobe.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC_LEN = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC_LEN = 2,
   parameter int V_BACK     = 33,
   parameter bit H_SYNC_POL = 1'b0,
   parameter bit V_SYNC_POL = 1'b0,
   parameter int CNT_W      = 12,
   parameter int FC_W       = 8
) (
   input  logic             CLOCK,
   input  logic             RESET_N,
   input  logic             PIXEL_EN,
   input  logic             FRAME_RESTART,
   output logic [CNT_W-1:0] CURRENT_PIXEL,
   output logic [CNT_W-1:0] CURRENT_LINE,
   output logic             H_SYNC,
   output logic             V_SYNC,
   output logic             ACTIVE,
   output logic             END_LINE,
   output logic             END_FRAME,
   output logic [FC_W-1:0]  FRAME_COUNT
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC_LEN + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC_LEN + V_BACK;

   localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS        = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS        = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_VISIBLE + H_FRONT);
   localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC_LEN);
   localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_VISIBLE + V_FRONT);
   localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC_LEN);

   logic [CNT_W-1:0] pixel_nxt;
   logic [CNT_W-1:0] line_nxt;
   logic [FC_W-1:0]  frame_count_nxt;
   logic             h_sync_nxt;
   logic             v_sync_nxt;
   logic             active_nxt;
   logic             end_line_nxt;
   logic             end_frame_nxt;
   // Cleared in the reset/restart parking state so that the first step onto (0,0) is not
   // mistaken for a real wrap and produces no strobes or frame increment.
   logic             primed;
   logic             primed_nxt;

   always_comb begin
      pixel_nxt       = CURRENT_PIXEL;
      line_nxt        = CURRENT_LINE;
      frame_count_nxt = FRAME_COUNT;
      primed_nxt      = primed;
      end_line_nxt    = 1'b0;
      end_frame_nxt   = 1'b0;

      if (FRAME_RESTART) begin
         pixel_nxt  = H_LAST;
         line_nxt   = V_LAST;
         primed_nxt = 1'b0;
      end else if (PIXEL_EN) begin
         primed_nxt = 1'b1;
         if (CURRENT_PIXEL == H_LAST) begin
            pixel_nxt    = '0;
            end_line_nxt = primed;
            if (CURRENT_LINE == V_LAST) begin
               line_nxt      = '0;
               end_frame_nxt = primed;
               if (primed) begin
                  frame_count_nxt = FRAME_COUNT + FC_W'(1);
               end
            end else begin
               line_nxt = CURRENT_LINE + CNT_W'(1);
            end
         end else begin
            pixel_nxt = CURRENT_PIXEL + CNT_W'(1);
         end
      end

      // Level outputs decode the next counts so they line up with the registered position.
      h_sync_nxt = ((pixel_nxt >= H_SYNC_START) && (pixel_nxt < H_SYNC_END)) ? H_SYNC_POL : ~H_SYNC_POL;
      v_sync_nxt = ((line_nxt >= V_SYNC_START) && (line_nxt < V_SYNC_END)) ? V_SYNC_POL : ~V_SYNC_POL;
      active_nxt = (pixel_nxt < H_VIS) && (line_nxt < V_VIS);
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         CURRENT_PIXEL <= H_LAST;
         CURRENT_LINE  <= V_LAST;
         H_SYNC        <= ~H_SYNC_POL;
         V_SYNC        <= ~V_SYNC_POL;
         ACTIVE        <= 1'b0;
         END_LINE      <= 1'b0;
         END_FRAME     <= 1'b0;
         FRAME_COUNT   <= '0;
         primed        <= 1'b0;
      end else begin
         CURRENT_PIXEL <= pixel_nxt;
         CURRENT_LINE  <= line_nxt;
         H_SYNC        <= h_sync_nxt;
         V_SYNC        <= v_sync_nxt;
         ACTIVE        <= active_nxt;
         END_LINE      <= end_line_nxt;
         END_FRAME     <= end_frame_nxt;
         FRAME_COUNT   <= frame_count_nxt;
         primed        <= primed_nxt;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance for line-level timing and a
// tiny 8x6 active-high instance for frame wrap, counter wrap and mid-line reset.
module tb_vga_timing_gen;

   logic CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   logic        a_rst_n, a_en, a_restart;
   logic [11:0] a_pixel, a_line;
   logic        a_hsync, a_vsync, a_active, a_end_line, a_end_frame;
   logic [7:0]  a_fc;

   logic        b_rst_n, b_en, b_restart;
   logic [3:0]  b_pixel, b_line;
   logic        b_hsync, b_vsync, b_active, b_end_line, b_end_frame;
   logic [7:0]  b_fc;

   int errors = 0;
   int checks = 0;

   vga_timing_gen u_a (
      .CLOCK(CLOCK), .RESET_N(a_rst_n), .PIXEL_EN(a_en), .FRAME_RESTART(a_restart),
      .CURRENT_PIXEL(a_pixel), .CURRENT_LINE(a_line), .H_SYNC(a_hsync), .V_SYNC(a_vsync),
      .ACTIVE(a_active), .END_LINE(a_end_line), .END_FRAME(a_end_frame), .FRAME_COUNT(a_fc)
   );

   vga_timing_gen #(
      .H_VISIBLE(4), .H_FRONT(1), .H_SYNC_LEN(2), .H_BACK(1),
      .V_VISIBLE(3), .V_FRONT(1), .V_SYNC_LEN(1), .V_BACK(1),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(4), .FC_W(8)
   ) u_b (
      .CLOCK(CLOCK), .RESET_N(b_rst_n), .PIXEL_EN(b_en), .FRAME_RESTART(b_restart),
      .CURRENT_PIXEL(b_pixel), .CURRENT_LINE(b_line), .H_SYNC(b_hsync), .V_SYNC(b_vsync),
      .ACTIVE(b_active), .END_LINE(b_end_line), .END_FRAME(b_end_frame), .FRAME_COUNT(b_fc)
   );

   logic [36:0] a_obs;
   logic [20:0] b_obs;
   assign a_obs = {a_pixel, a_line, a_hsync, a_vsync, a_active, a_end_line, a_end_frame, a_fc};
   assign b_obs = {b_pixel, b_line, b_hsync, b_vsync, b_active, b_end_line, b_end_frame, b_fc};

   // m is the index of the position reached (0 = first (0,0)); m < 0 is the parked state.
   function automatic logic [36:0] model_a(int m, bit strobe);
      int px, ln;
      logic h, v, act, el, ef;
      if (m < 0) return {12'd799, 12'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      px  = m % 800;
      ln  = (m / 800) % 525;
      h   = !(px >= 656 && px <= 751);
      v   = !(ln >= 490 && ln <= 491);
      act = (px < 640) && (ln < 480);
      el  = strobe && (px == 0) && (m >= 800);
      ef  = strobe && (px == 0) && (ln == 0) && (m >= 420000);
      return {12'(px), 12'(ln), h, v, act, el, ef, 8'(m / 420000)};
   endfunction

   function automatic logic [20:0] model_b(int m, bit strobe);
      int px, ln;
      logic h, v, act, el, ef;
      if (m < 0) return {4'd7, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      px  = m % 8;
      ln  = (m / 8) % 6;
      h   = (px == 5) || (px == 6);
      v   = (ln == 4);
      act = (px < 4) && (ln < 3);
      el  = strobe && (px == 0) && (m >= 8);
      ef  = strobe && (px == 0) && (ln == 0) && (m >= 48);
      return {4'(px), 4'(ln), h, v, act, el, ef, 8'(m / 48)};
   endfunction

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic test_reset();
      logic [36:0] ea;
      logic [20:0] eb;
      a_rst_n = 1'b0; b_rst_n = 1'b0;
      a_en = 1'b1; b_en = 1'b1; a_restart = 1'b0; b_restart = 1'b0;
      #23;
      ea = model_a(-1, 1'b0);
      eb = model_b(-1, 1'b0);
      checks++;
      if (a_obs !== ea) begin
         errors++;
         $display("[TB] FAIL reset_a got=%h required=%h", a_obs, ea);
      end
      checks++;
      if (b_obs !== eb) begin
         errors++;
         $display("[TB] FAIL reset_b got=%h required=%h", b_obs, eb);
      end
      a_en = 1'b0; b_en = 1'b0;
      step();
      a_rst_n = 1'b1; b_rst_n = 1'b1;
      step();
      checks++;
      if (a_obs !== ea) begin
         errors++;
         $display("[TB] FAIL reset_hold_a got=%h required=%h", a_obs, ea);
      end
   endtask

   task automatic test_line_sweep();
      logic [36:0] ea;
      a_en = 1'b1;
      for (int m = 0; m < 1700; m++) begin
         step();
         ea = model_a(m, 1'b1);
         checks++;
         if (a_obs !== ea) begin
            errors++;
            $display("[TB] FAIL line_sweep m=%0d got=%h required=%h", m, a_obs, ea);
         end
      end
      a_en = 1'b0;
   endtask

   task automatic test_restart();
      logic [36:0] ea;
      logic [20:0] eb;
      a_restart = 1'b1;
      step();
      a_restart = 1'b0;
      ea = model_a(-1, 1'b0);
      checks++;
      if (a_obs !== ea) begin
         errors++;
         $display("[TB] FAIL restart_idle_a got=%h required=%h", a_obs, ea);
      end
      a_en = 1'b1;
      for (int m = 0; m <= 1100; m++) begin
         step();
      end
      ea = model_a(1100, 1'b1);
      checks++;
      if (a_obs !== ea) begin
         errors++;
         $display("[TB] FAIL restart_pre_a got=%h required=%h", a_obs, ea);
      end
      a_restart = 1'b1;
      step();
      a_restart = 1'b0;
      ea = model_a(-1, 1'b0);
      checks++;
      if (a_obs !== ea) begin
         errors++;
         $display("[TB] FAIL restart_a got=%h required=%h", a_obs, ea);
      end
      step();
      ea = model_a(0, 1'b1);
      checks++;
      if (a_obs !== ea) begin
         errors++;
         $display("[TB] FAIL restart_first_a got=%h required=%h", a_obs, ea);
      end
      a_en = 1'b0;

      b_en = 1'b1;
      for (int m = 0; m <= 19; m++) begin
         step();
      end
      eb = model_b(19, 1'b1);
      checks++;
      if (b_obs !== eb) begin
         errors++;
         $display("[TB] FAIL restart_pre_b got=%h required=%h", b_obs, eb);
      end
      b_restart = 1'b1;
      step();
      b_restart = 1'b0;
      eb = model_b(-1, 1'b0);
      checks++;
      if (b_obs !== eb) begin
         errors++;
         $display("[TB] FAIL restart_b got=%h required=%h", b_obs, eb);
      end
      step();
      eb = model_b(0, 1'b1);
      checks++;
      if (b_obs !== eb) begin
         errors++;
         $display("[TB] FAIL restart_first_b got=%h required=%h", b_obs, eb);
      end
      b_en = 1'b0;
   endtask

   // Continues from position 0 left by test_restart, strobing every second clock.
   task automatic test_half_rate();
      logic [36:0] ea;
      for (int m = 1; m <= 1700; m++) begin
         a_en = 1'b1;
         step();
         ea = model_a(m, 1'b1);
         checks++;
         if (a_obs !== ea) begin
            errors++;
            $display("[TB] FAIL half_rate_on m=%0d got=%h required=%h", m, a_obs, ea);
         end
         a_en = 1'b0;
         step();
         ea = model_a(m, 1'b0);
         checks++;
         if (a_obs !== ea) begin
            errors++;
            $display("[TB] FAIL half_rate_off m=%0d got=%h required=%h", m, a_obs, ea);
         end
      end
   endtask

   task automatic test_frame_wrap();
      logic [20:0] eb;
      b_rst_n = 1'b0;
      #2;
      b_rst_n = 1'b1;
      b_en = 1'b1;
      for (int m = 0; m <= 256 * 48; m++) begin
         step();
         eb = model_b(m, 1'b1);
         checks++;
         if (b_obs !== eb) begin
            errors++;
            $display("[TB] FAIL frame_wrap m=%0d got=%h required=%h", m, b_obs, eb);
         end
      end
   endtask

   // Continues from the frame-256 wrap; resets while END_LINE is high.
   task automatic test_reset_midline();
      logic [20:0] eb;
      for (int m = 256 * 48 + 1; m <= 256 * 48 + 8; m++) begin
         step();
      end
      eb = model_b(8, 1'b1);
      checks++;
      if (b_obs !== eb) begin
         errors++;
         $display("[TB] FAIL midline_pre got=%h required=%h", b_obs, eb);
      end
      #2;
      b_rst_n = 1'b0;
      #1;
      eb = model_b(-1, 1'b0);
      checks++;
      if (b_obs !== eb) begin
         errors++;
         $display("[TB] FAIL midline_reset got=%h required=%h", b_obs, eb);
      end
      step();
      checks++;
      if (b_obs !== eb) begin
         errors++;
         $display("[TB] FAIL midline_reset_hold got=%h required=%h", b_obs, eb);
      end
      b_rst_n = 1'b1;
      step();
      eb = model_b(0, 1'b1);
      checks++;
      if (b_obs !== eb) begin
         errors++;
         $display("[TB] FAIL midline_release got=%h required=%h", b_obs, eb);
      end
      b_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_line_sweep();
      test_restart();
      test_half_rate();
      test_frame_wrap();
      test_reset_midline();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
